multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control FSM for the multicycle RV64I datapath. Sequences each instruction through fetch, decode, execute, memory and write-back. Drives every datapath mux select and write enable: PC, IR, register file, memory, ALU operand and operation selects. Sits beside the register file, ALU, immediate generator and unified memory port, and stalls on memory wait states.

## Interface
Parameters:
- STATE_W, 4, width of the exported state code

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- opcode  in  7  instruction[6:0] from the instruction register
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero flag set (branch)
- ir_write  out  1  load instruction register from memory data
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- iord  out  1  memory address: 0=PC, 1=ALUOut
- reg_write  out  1  register file write enable
- mem_to_reg  out  2  write-back source: 0=ALUOut, 1=MDR, 2=PC
- alu_src_a  out  2  0=PC, 1=A (rs1), 2=old_pc
- alu_src_b  out  2  0=B (rs2), 1=constant 4, 2=immediate
- alu_op  out  2  00=add, 01=subtract/compare, 10=funct-decoded
- pc_source  out  2  0=ALU result, 1=ALUOut, 2=ALU result with bit0 cleared
- halted  out  1  illegal opcode seen; sticky until reset
- state  out  STATE_W  current state code, for debug

## Operation
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, EXEC_I=7, ALU_WB=8, BRANCH=9, JAL=10, JALR=11, HALT=12.
- Every output not listed for a state is 0.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=00, pc_source=0.
  - ir_write and pc_write equal mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=2, alu_src_b=2, alu_op=00. ALUOut latches the branch/JAL target. Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - any other opcode -> HALT
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=10 -> ALU_WB.
- EXEC_I: alu_src_a=1, alu_src_b=2, alu_op=10 -> ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0 -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=00. Load -> MEM_RD; store -> MEM_WR.
- MEM_RD: mem_read=1, iord=1. Hold until mem_ready, then -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1 -> FETCH.
- MEM_WR: mem_write=1, iord=1. Hold until mem_ready, then -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=01, pc_write_cond=1, pc_source=1 -> FETCH.
- JAL: pc_write=1, pc_source=1, reg_write=1, mem_to_reg=2 -> FETCH.
  - The link value is PC+4, because PC was already updated in FETCH.
- JALR: alu_src_a=1, alu_src_b=2, alu_op=00, pc_write=1, pc_source=2, reg_write=1, mem_to_reg=2 -> FETCH.
- HALT: halted=1, all enables 0. Self-loop until reset.
- opcode is sampled only in DECODE and MEM_ADDR. The IR is stable after FETCH completes.

## Timing
- Outputs are Moore decodes of the state register. The exceptions are ir_write and pc_write in FETCH, which are gated by mem_ready (Mealy).
- Cycles per instruction with zero wait states:
  - R-type / I-type: 4
  - load: 5
  - store: 4
  - branch: 3
  - jal: 3
  - jalr: 3
- Each wait cycle (mem_ready=0) adds exactly 1 cycle, with request outputs held constant.
- Reset:
  - While reset=1, all write enables are 0 and state=FETCH.
  - On the first cycle after reset deasserts, mem_read=1 and iord=0.
  - Reset during MEM_RD/MEM_WR/FETCH aborts the access, and no write enable asserts that cycle.
  - Reset in HALT clears halted on the next edge.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.

## Structure
- Shared package holds:
  - State enum codes.
  - RV opcode constants: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR.
  - Mux encodings for mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source.
- The same package is used by the immediate generator and the ALU control.
- One natural sub-module is control_decode: a purely combinational state/opcode to control-word decoder. The top holds only the state register and next-state logic.

## Test plan
- Reset, then opcode=0110011 with mem_ready=1 throughout -> states 0,1,6,8,0. reg_write=1 only in cycle 4.
- Load (0000011) with mem_ready low for 2 cycles in MEM_RD -> 7 cycles total. mem_read and iord=1 held during the wait; reg_write=1 with mem_to_reg=1 in the last cycle.
- Store (0100011) with 1 FETCH wait cycle -> ir_write and pc_write stay 0 while mem_ready=0. mem_write=1 in MEM_WR; no reg_write at any point.
- Branch, JAL and JALR back-to-back -> 3 cycles each, in that order:
  - BRANCH: pc_write_cond=1 with pc_source=1.
  - JAL: pc_write=1 with mem_to_reg=2.
  - JALR: pc_source=2.
- opcode=0000000 in DECODE -> HALT from the next cycle: halted=1, no further mem_read. reset=1 for 1 cycle -> FETCH, halted=0.
- Assert reset in MEM_WR while mem_ready=0 -> mem_write=0 and state=FETCH after the edge.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle RV64I control path: state codes,
// base opcodes, datapath mux encodings and the packed control word.
// Also used by the immediate generator and the ALU control.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    localparam logic [1:0] SRCA_PC     = 2'd0;
    localparam logic [1:0] SRCA_RS1    = 2'd1;
    localparam logic [1:0] SRCA_OLD_PC = 2'd2;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU     = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT  = 2'd1;
    localparam logic [1:0] PCSRC_ALU_JR  = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       halted;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational state -> control word decoder.
// Ports: state (current FSM state), mem_ready (memory handshake, only
// meaningful in FETCH), ctrl (full control word for the datapath).
module multicycle_control_decode
    import multicycle_control_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_a = SRCA_PC;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                // IR and PC advance only on the cycle the fetch completes.
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_a = SRCA_OLD_PC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = M2R_MDR;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALU_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = M2R_ALUOUT;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = SRCA_RS1;
                ctrl.alu_src_b     = SRCB_RS2;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JAL: begin
                // PC already holds PC+4 from FETCH, so it is the link value.
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_ALUOUT;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = M2R_PC;
            end
            S_JALR: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_ALU_JR;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = M2R_PC;
            end
            S_HALT: begin
                ctrl.halted = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV64I datapath.
// Ports: clk, reset (sync, active-high), opcode (IR[6:0]), mem_ready
// (memory handshake); outputs are the datapath write enables and mux
// selects, halted (sticky illegal-opcode flag) and the debug state code.
//
// state    | meaning
// ---------+------------------------------------------------------
// FETCH    | read IR from memory at PC, PC <= PC+4 on mem_ready
// DECODE   | ALUOut <= old_pc + imm (branch/JAL target), dispatch
// MEM_ADDR | ALUOut <= rs1 + imm
// MEM_RD   | load read at ALUOut, wait for mem_ready
// MEM_WB   | rd <= MDR
// MEM_WR   | store write at ALUOut, wait for mem_ready
// EXEC_R   | ALUOut <= rs1 op rs2
// EXEC_I   | ALUOut <= rs1 op imm
// ALU_WB   | rd <= ALUOut
// BRANCH   | compare rs1/rs2, PC <= ALUOut if zero
// JAL      | PC <= ALUOut, rd <= PC
// JALR     | PC <= (rs1 + imm) & ~1, rd <= PC
// HALT     | illegal opcode, parked until reset
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               ir_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               iord,
    output logic               reg_write,
    output logic [1:0]         mem_to_reg,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               halted,
    output logic [STATE_W-1:0] state
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_raw;
    ctrl_t  ctrl;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                unique case (opcode)
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    default:           state_d = S_HALT;
                endcase
            end
            S_MEM_ADDR: state_d = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
            S_EXEC_R,
            S_EXEC_I:   state_d = S_ALU_WB;
            S_MEM_WB,
            S_ALU_WB,
            S_BRANCH,
            S_JAL,
            S_JALR:     state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    multicycle_control_decode u_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl_raw)
    );

    // Reset kills any in-flight access combinationally so nothing is
    // written in the reset cycle; halted stays visible until the edge.
    always_comb begin
        ctrl = ctrl_raw;
        if (reset) begin
            ctrl        = '0;
            ctrl.halted = ctrl_raw.halted;
        end
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign ir_write      = ctrl.ir_write;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign iord          = ctrl.iord;
    assign reg_write     = ctrl.reg_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign halted        = ctrl.halted;
    assign state         = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, iord;
    logic       reg_write, halted;
    logic [1:0] mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_control #(.STATE_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .ir_write      (ir_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .iord          (iord),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .halted        (halted),
        .state         (state)
    );

    logic [17:0] obs_w;
    assign obs_w = {pc_write, pc_write_cond, ir_write, mem_read, mem_write, iord,
                    reg_write, halted, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                    pc_source};

    // Expected control word built from named fields.
    function automatic logic [17:0] cw(input bit pw, input bit pwc, input bit irw,
                                       input bit mr, input bit mw, input bit io,
                                       input bit rw, input bit h, input int m2r,
                                       input int sa, input int sb, input int op,
                                       input int ps);
        return {pw, pwc, irw, mr, mw, io, rw, h, 2'(m2r), 2'(sa), 2'(sb), 2'(op), 2'(ps)};
    endfunction

    logic [17:0] W_ZERO, W_FETCH, W_FWAIT, W_DEC, W_EXR, W_EXI, W_AWB, W_MADDR;
    logic [17:0] W_MRD, W_MWB, W_MWR, W_BR, W_JAL, W_JALR, W_HALT;

    // One clock: drive inputs, sample at the falling edge, advance past posedge.
    task automatic cyc(input string tag, input bit rst, input bit rdy,
                       input logic [6:0] op, input int exp_st, input logic [17:0] exp_w);
        reset     = rst;
        mem_ready = rdy;
        opcode    = op;
        @(negedge clk);
        checks++;
        assert (state === 4'(exp_st)) else begin
            errors++;
            $error("FAIL %s state observed=%0d expected=%0d", tag, state, exp_st);
        end
        checks++;
        assert (obs_w === exp_w) else begin
            errors++;
            $error("FAIL %s ctrl observed=%05h expected=%05h", tag, obs_w, exp_w);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        W_ZERO  = '0;
        W_FETCH = cw(1,0,1,1,0,0,0,0, 0,0,1,0,0);
        W_FWAIT = cw(0,0,0,1,0,0,0,0, 0,0,1,0,0);
        W_DEC   = cw(0,0,0,0,0,0,0,0, 0,2,2,0,0);
        W_EXR   = cw(0,0,0,0,0,0,0,0, 0,1,0,2,0);
        W_EXI   = cw(0,0,0,0,0,0,0,0, 0,1,2,2,0);
        W_AWB   = cw(0,0,0,0,0,0,1,0, 0,0,0,0,0);
        W_MADDR = cw(0,0,0,0,0,0,0,0, 0,1,2,0,0);
        W_MRD   = cw(0,0,0,1,0,1,0,0, 0,0,0,0,0);
        W_MWB   = cw(0,0,0,0,0,0,1,0, 1,0,0,0,0);
        W_MWR   = cw(0,0,0,0,1,1,0,0, 0,0,0,0,0);
        W_BR    = cw(0,1,0,0,0,0,0,0, 0,1,0,1,1);
        W_JAL   = cw(1,0,0,0,0,0,1,0, 2,0,0,0,1);
        W_JALR  = cw(1,0,0,0,0,0,1,0, 2,1,2,0,2);
        W_HALT  = cw(0,0,0,0,0,0,0,1, 0,0,0,0,0);

        reset = 1'b1; mem_ready = 1'b0; opcode = 7'd0;
        @(posedge clk); #1;
        cyc("reset_hold", 1, 1, 7'b0110011, 0, W_ZERO);

        // R-type, no waits: 0,1,6,8
        cyc("r_fetch",  0, 1, 7'b0110011, 0, W_FETCH);
        cyc("r_decode", 0, 0, 7'b0110011, 1, W_DEC);
        cyc("r_exec",   0, 1, 7'b0110011, 6, W_EXR);
        cyc("r_wb",     0, 0, 7'b0110011, 8, W_AWB);

        // Load with two MEM_RD wait cycles: 7 cycles
        cyc("ld_fetch", 0, 1, 7'b0000011, 0, W_FETCH);
        cyc("ld_dec",   0, 1, 7'b0000011, 1, W_DEC);
        cyc("ld_addr",  0, 1, 7'b0000011, 2, W_MADDR);
        cyc("ld_wait1", 0, 0, 7'b0000011, 3, W_MRD);
        cyc("ld_wait2", 0, 0, 7'b0000011, 3, W_MRD);
        cyc("ld_rd",    0, 1, 7'b0000011, 3, W_MRD);
        cyc("ld_wb",    0, 1, 7'b0000011, 4, W_MWB);

        // Store with one FETCH wait cycle
        cyc("st_fwait", 0, 0, 7'b0100011, 0, W_FWAIT);
        cyc("st_fetch", 0, 1, 7'b0100011, 0, W_FETCH);
        cyc("st_dec",   0, 1, 7'b0100011, 1, W_DEC);
        cyc("st_addr",  0, 1, 7'b0100011, 2, W_MADDR);
        cyc("st_wr",    0, 1, 7'b0100011, 5, W_MWR);

        // Branch, JAL, JALR back to back
        cyc("br_fetch", 0, 1, 7'b1100011, 0, W_FETCH);
        cyc("br_dec",   0, 1, 7'b1100011, 1, W_DEC);
        cyc("br_exec",  0, 1, 7'b1100011, 9, W_BR);
        cyc("jal_fetch",0, 1, 7'b1101111, 0, W_FETCH);
        cyc("jal_dec",  0, 1, 7'b1101111, 1, W_DEC);
        cyc("jal_exec", 0, 1, 7'b1101111, 10, W_JAL);
        cyc("jr_fetch", 0, 1, 7'b1100111, 0, W_FETCH);
        cyc("jr_dec",   0, 1, 7'b1100111, 1, W_DEC);
        cyc("jr_exec",  0, 1, 7'b1100111, 11, W_JALR);

        // I-type
        cyc("i_fetch",  0, 1, 7'b0010011, 0, W_FETCH);
        cyc("i_dec",    0, 1, 7'b0010011, 1, W_DEC);
        cyc("i_exec",   0, 1, 7'b0010011, 7, W_EXI);
        cyc("i_wb",     0, 1, 7'b0010011, 8, W_AWB);

        // Illegal opcode -> HALT, sticky, cleared by a one-cycle reset
        cyc("h_fetch",  0, 1, 7'b0000000, 0, W_FETCH);
        cyc("h_dec",    0, 1, 7'b0000000, 1, W_DEC);
        cyc("h_halt1",  0, 1, 7'b0110011, 12, W_HALT);
        cyc("h_halt2",  0, 1, 7'b0000011, 12, W_HALT);
        cyc("h_rst",    1, 1, 7'b0000000, 12, W_HALT);
        cyc("h_after",  0, 0, 7'b0000000, 0, W_FWAIT);

        // Reset while MEM_WR is waiting
        cyc("rw_fetch", 0, 1, 7'b0100011, 0, W_FETCH);
        cyc("rw_dec",   0, 1, 7'b0100011, 1, W_DEC);
        cyc("rw_addr",  0, 1, 7'b0100011, 2, W_MADDR);
        cyc("rw_wait",  0, 0, 7'b0100011, 5, W_MWR);
        cyc("rw_rst",   1, 0, 7'b0100011, 5, W_ZERO);
        cyc("rw_after", 0, 0, 7'b0100011, 0, W_FWAIT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
